// File: rtl/icache_2way.sv
// rtl/icache_2way.sv - 2-way set-associative read-only instruction cache
//
// Purpose: sits between CPU fetch and memory. Multi-word lines, one LRU bit
// per set, blocking refill with one outstanding memory word request, and a
// flush that invalidates every line in one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_req, cpu_addr   fetch request, held stable until cpu_valid
//   flush               invalidate-all pulse (deferred while a refill runs)
//   cpu_valid,cpu_rdata one-cycle response pulse with the fetched word
//   busy                high whenever the controller is not IDLE
//   mem_req, mem_addr   refill word request, held until mem_rvalid
//   mem_rvalid,mem_rdata refill word return
//   hit_cnt, miss_cnt   lookup counters, present only with ICACHE_PERF_CNT_EN
//
// Build option: define ICACHE_PERF_CNT_EN to add the hit/miss counters.

module icache_2way #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  // Word counter is at least one bit wide so single-word lines still elaborate.
  localparam int WW    = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_FLUSH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              victim_q;
  logic [WW-1:0]     cnt_q;
  logic              flush_pend_q;
  logic              cpu_valid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              busy_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q  [2][SETS];
  logic [DATA_W-1:0] data_q [2][SETS][LINE_WORDS];

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[2+OFF_W +: IDX_W];
  endfunction

  function automatic logic [WW-1:0] word_of(input logic [ADDR_W-1:0] a);
    if (OFF_W == 0) return '0;
    return a[2 +: WW];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [WW-1:0]    w);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1 -: TAG_W] = t;
    a[2+OFF_W +: IDX_W]  = i;
    if (OFF_W > 0) a[2 +: WW] = w;
    return a;
  endfunction

  // Lookup side: decoded straight from the live CPU address.
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [WW-1:0]     lk_word;
  logic              hit0, hit1, hit, hit_way, miss_victim;
  logic [DATA_W-1:0] hit_word;

  assign lk_idx   = idx_of(cpu_addr);
  assign lk_tag   = tag_of(cpu_addr);
  assign lk_word  = word_of(cpu_addr);
  assign hit0     = valid_q[0][lk_idx] && (tag_q[0][lk_idx] == lk_tag);
  assign hit1     = valid_q[1][lk_idx] && (tag_q[1][lk_idx] == lk_tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_word = data_q[hit_way][lk_idx][lk_word];
  // Fill empty ways first (way0 before way1); only evict when the set is full.
  assign miss_victim = !valid_q[0][lk_idx] ? 1'b0 :
                       !valid_q[1][lk_idx] ? 1'b1 : lru_q[lk_idx];

  // Refill side: decoded from the address latched at miss time.
  logic [IDX_W-1:0] rf_idx;
  logic [TAG_W-1:0] rf_tag;
  logic [WW-1:0]    rf_word;
  logic             refill_we, rf_last;

  assign rf_idx    = idx_of(req_addr_q);
  assign rf_tag    = tag_of(req_addr_q);
  assign rf_word   = word_of(req_addr_q);
  // A return only counts while a word request is actually open.
  assign refill_we = (state_q == S_REFILL) && mem_req_q && mem_rvalid;
  assign rf_last   = (cnt_q == WW'(LINE_WORDS - 1));

  // Line storage: data and tags carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!rst && refill_we) begin
      data_q[victim_q][rf_idx][cnt_q] <= mem_rdata;
      if (rf_last) tag_q[victim_q][rf_idx] <= rf_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      victim_q     <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      cpu_valid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
`ifdef ICACHE_PERF_CNT_EN
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
`endif
    end else begin
      cpu_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush || flush_pend_q) begin
            state_q <= S_FLUSH;
            busy_q  <= 1'b1;
          end else if (cpu_req) begin
            if (hit) begin
              cpu_rdata_q    <= hit_word;
              cpu_valid_q    <= 1'b1;
              lru_q[lk_idx]  <= ~hit_way;
`ifdef ICACHE_PERF_CNT_EN
              hit_cnt_q      <= hit_cnt_q + 32'd1;
`endif
            end else begin
              req_addr_q <= cpu_addr;
              victim_q   <= miss_victim;
              cnt_q      <= '0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= line_addr(lk_tag, lk_idx, '0);
              state_q    <= S_REFILL;
              busy_q     <= 1'b1;
`ifdef ICACHE_PERF_CNT_EN
              miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        S_REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (refill_we) begin
            if (rf_last) begin
              cnt_q                     <= '0;
              mem_req_q                 <= 1'b0;
              valid_q[victim_q][rf_idx] <= 1'b1;
              lru_q[rf_idx]             <= ~victim_q;
              state_q                   <= S_RESP;
            end else begin
              cnt_q      <= WW'(cnt_q + 1'b1);
              mem_addr_q <= line_addr(rf_tag, rf_idx, WW'(cnt_q + 1'b1));
            end
          end
        end
        S_RESP: begin
          if (flush) flush_pend_q <= 1'b1;
          cpu_rdata_q <= data_q[victim_q][rf_idx][rf_word];
          cpu_valid_q <= 1'b1;
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
        end
        S_FLUSH: begin
          valid_q[0]   <= '0;
          valid_q[1]   <= '0;
          lru_q        <= '0;
          flush_pend_q <= 1'b0;
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_valid = cpu_valid_q;
  assign cpu_rdata = cpu_rdata_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache_2way.sv
// tb/tb_icache_2way.sv - self-checking bench for icache_2way

module tb_icache_2way;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        flush;
  logic        cpu_valid;
  logic [31:0] cpu_rdata;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_2way dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .flush     (flush),
    .cpu_valid (cpu_valid),
    .cpu_rdata (cpu_rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_data_q[$];
  logic [15:0] exp_maddr_q[$];

  int  mem_delay   = 0;
  int  wait_cnt    = 0;
  int  last_rv_cyc = 0;
  bit  chk_drop    = 0;
  bit  stray_req   = 0;
  logic [15:0] held_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents: the 0x0100 line holds 0xA0..0xA3, everything else is address-tagged.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a >= 16'h0100 && a <= 16'h010F) return 32'h0000_00A0 + 32'(a[3:2]);
    return {16'hC0DE, a[15:2], 2'b00};
  endfunction

  // Memory responder: acts 2 ns after each edge, checks addresses against the scoreboard.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      mem_rvalid = 1'b0;
      if (chk_drop) begin
        check("mem_req_drop", mem_req, 0);
        chk_drop = 0;
      end
      if (rst) begin
        wait_cnt = 0;
      end else if (stray_req) begin
        stray_req  = 0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end else if (mem_req) begin
        if (wait_cnt == 0) held_addr = mem_addr;
        else check("mem_addr_stable", mem_addr, held_addr);
        if (wait_cnt < mem_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          if (exp_maddr_q.size() == 0) begin
            check("unexpected_mem_req", mem_req, 0);
          end else begin
            check("mem_addr", mem_addr, exp_maddr_q.pop_front());
            if (exp_maddr_q.size() == 0) chk_drop = 1;
          end
          mem_rvalid  = 1'b1;
          mem_rdata   = mem_word(mem_addr);
          last_rv_cyc = cyc;
        end
      end else begin
        if (wait_cnt > 0) check("mem_req_held", mem_req, 1);
        wait_cnt = 0;
      end
    end
  end

  task automatic fetch(input logic [15:0] addr, input bit exp_miss, input int flush_at,
                       output int lat);
    bit saw_mem;
    bit done;
    logic [15:0] base;
    exp_data_q.push_back(mem_word({addr[15:2], 2'b00}));
    base = addr & 16'hFFF0;
    if (exp_miss)
      for (int w = 0; w < 4; w++) exp_maddr_q.push_back(base + 16'(w * 4));
    cpu_req  = 1'b1;
    cpu_addr = addr;
    saw_mem  = 0;
    done     = 0;
    lat      = 0;
    for (int i = 1; i <= 300 && !done; i++) begin
      @(posedge clk); #1;
      flush = (i == flush_at);
      if (mem_req) saw_mem = 1;
      if (cpu_valid) begin
        done = 1;
        lat  = i;
        check($sformatf("rdata_%0h", addr), cpu_rdata, exp_data_q.pop_front());
      end
    end
    flush   = 1'b0;
    cpu_req = 1'b0;
    if (!done) begin
      check($sformatf("timeout_%0h", addr), cpu_valid, 1);
      void'(exp_data_q.pop_front());
    end
    check($sformatf("mem_activity_%0h", addr), saw_mem, exp_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int lat;
  int n_rv;

  initial begin
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_valid", cpu_valid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_busy",      busy,      0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss then hit in the same line.
    fetch(16'h0104, 1, -1, lat);
    check("cold_miss_latency", lat, 6);
    check("valid_after_last_rv", cyc - last_rv_cyc, 2);
    fetch(16'h010C, 0, -1, lat);
    check("hit_latency", lat, 1);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_1",  hit_cnt,  1);
    check("miss_cnt_1", miss_cnt, 1);
`endif

    // Back-to-back hits: a new address every cycle, one word per cycle.
    cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 16'h0100 + 16'(i * 4);
      exp_data_q.push_back(mem_word(cpu_addr));
      @(posedge clk); #1;
      check("b2b_valid", cpu_valid, 1);
      check("b2b_rdata", cpu_rdata, exp_data_q.pop_front());
      check("b2b_no_mem", mem_req, 0);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;

    // LRU: same set, three tags.
    fetch(16'h1100, 1, -1, lat);
    check("way1_fill_latency", lat, 6);
    fetch(16'h0100, 0, -1, lat);
    fetch(16'h2100, 1, -1, lat);
    fetch(16'h0100, 0, -1, lat);
    fetch(16'h1100, 1, -1, lat);

    // Stray return while idle must be ignored.
    stray_req = 1;
    repeat (2) @(posedge clk);
    #1;
    check("stray_busy",    busy,    0);
    check("stray_mem_req", mem_req, 0);
    fetch(16'h0108, 0, -1, lat);

    // Stalled memory: each word delayed 5 cycles.
    mem_delay = 5;
    fetch(16'h0304, 1, -1, lat);
    check("stall_latency", lat, 4 * 6 + 2);
    mem_delay = 0;
    fetch(16'h0300, 0, -1, lat);

    // Flush mid-refill: refill finishes and answers, then the flush runs.
    fetch(16'h0404, 1, 2, lat);
    @(posedge clk); #1;
    check("flush_busy", busy, 1);
    @(posedge clk); #1;
    check("flush_done_busy", busy, 0);
    fetch(16'h0104, 1, -1, lat);
    fetch(16'h0404, 1, -1, lat);

    // Reset after the second refill word.
    cpu_req  = 1'b1;
    cpu_addr = 16'h0208;
    for (int w = 0; w < 4; w++) exp_maddr_q.push_back(16'h0200 + 16'(w * 4));
    n_rv = 0;
    for (int i = 0; i < 50 && n_rv < 2; i++) begin
      @(posedge clk); #1;
      if (mem_rvalid) n_rv++;
    end
    check("rst_mid_words_seen", n_rv, 2);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_mem_req",   mem_req,   0);
    check("rst_mid_busy",      busy,      0);
    check("rst_mid_cpu_valid", cpu_valid, 0);
    exp_maddr_q.delete();
    rst = 1'b0;
    fetch(16'h0104, 1, -1, lat);
    fetch(16'h0208, 1, -1, lat);
    fetch(16'h0200, 0, -1, lat);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt_after_rst",  hit_cnt,  1);
    check("miss_cnt_after_rst", miss_cnt, 2);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_data_empty", exp_data_q.size(), 0);
    check("scoreboard_addr_empty", exp_maddr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
